// File: rtl/uart_frame_arbiter.sv
// uart_frame_arbiter: round-robin arbiter in front of a byte UART.
// Frames 32-bit words as A5,id,d3..d0,xor and paces bytes on tx_done.
module uart_frame_arbiter #(
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter int         GAP_CYCLES = 2,
  parameter int         TIMEOUT    = 600000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [31:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [31:0] data1,
  output logic        ack1,
  output logic [7:0]  tx_data,
  output logic        tx_send_en,
  input  logic        tx_done,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GL = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 2);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GL);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    GAP,
    DONE
  } state_t;

  state_t        state, state_d;
  logic          gid, gid_d;
  logic [31:0]   word, word_d;
  logic [2:0]    idx, idx_d;
  logic [CW-1:0] wait_cnt, wait_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic          abort, abort_d;
  logic          rr, rr_d;

  logic          send_d;
  logic [7:0]    data_d;
  logic          ack0_d;
  logic          ack1_d;
  logic          err_d;
  logic          busy_d;

  function automatic logic [7:0] frame_byte(
    input logic [31:0] w,
    input logic        id,
    input logic [2:0]  i
  );
    logic [7:0] src;
    src = {7'd0, id};
    case (i)
      3'd0:    frame_byte = HEADER;
      3'd1:    frame_byte = src;
      3'd2:    frame_byte = w[31:24];
      3'd3:    frame_byte = w[23:16];
      3'd4:    frame_byte = w[15:8];
      3'd5:    frame_byte = w[7:0];
      default: frame_byte = src ^ w[31:24] ^ w[23:16]
                          ^ w[15:8] ^ w[7:0];
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gid      <= 1'b0;
      word     <= '0;
      idx      <= '0;
      wait_cnt <= '0;
      gap_cnt  <= '0;
      abort    <= 1'b0;
      rr       <= 1'b0;
    end else begin
      state    <= state_d;
      gid      <= gid_d;
      word     <= word_d;
      idx      <= idx_d;
      wait_cnt <= wait_d;
      gap_cnt  <= gap_d;
      abort    <= abort_d;
      rr       <= rr_d;
    end
  end

  always_comb begin
    state_d = state;
    gid_d   = gid;
    word_d  = word;
    idx_d   = idx;
    wait_d  = wait_cnt;
    gap_d   = gap_cnt;
    abort_d = abort;
    rr_d    = rr;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_d = SEND;
          gid_d   = (req0 && req1) ? rr : req1;
          word_d  = gid_d ? data1 : data0;
          idx_d   = 3'd0;
          abort_d = 1'b0;
        end
      end
      SEND: begin
        state_d = WAIT;
        wait_d  = '0;
      end
      WAIT: begin
        wait_d = wait_cnt + CW'(1);
        // tx_done has priority over the watchdog on the same cycle
        if (tx_done) begin
          if (idx == 3'd6) begin
            state_d = DONE;
          end else begin
            idx_d = idx + 3'd1;
            if (GAP_CYCLES == 0) begin
              state_d = SEND;
            end else begin
              state_d = GAP;
              gap_d   = '0;
            end
          end
        end else if (wait_cnt == WAIT_LAST) begin
          abort_d = 1'b1;
          state_d = DONE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = SEND;
        end else begin
          gap_d = gap_cnt + GW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        rr_d    = ~gid;
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs are registered from the next state so they align with it
  always_comb begin
    send_d = (state_d == SEND);
    data_d = send_d ? frame_byte(word_d, gid_d, idx_d) : tx_data;
    ack0_d = (state_d == DONE) && !gid_d;
    ack1_d = (state_d == DONE) && gid_d;
    err_d  = (state_d == DONE) && abort_d;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_send_en <= 1'b0;
      tx_data    <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      tx_send_en <= send_d;
      tx_data    <= data_d;
      ack0       <= ack0_d;
      ack1       <= ack1_d;
      err        <= err_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// tb_uart_frame_arbiter: scoreboard bench with a tx_done transmitter model.
// Instance 0 uses GAP_CYCLES=2, instance 1 GAP_CYCLES=0; both TIMEOUT=100.
module tb_uart_frame_arbiter;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 [2];
  logic        req1 [2];
  logic [31:0] data0 [2];
  logic [31:0] data1 [2];
  logic        ack0 [2];
  logic        ack1 [2];
  logic [7:0]  tx_data [2];
  logic        tx_send_en [2];
  logic        tx_done [2];
  logic        busy [2];
  logic        err [2];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int dly [2];
  int stall_at [2];

  logic [7:0] byte_q [$];
  logic [1:0] ack_q [$];

  always #10 clk = ~clk;

  uart_frame_arbiter #(
    .HEADER(8'hA5), .GAP_CYCLES(2), .TIMEOUT(TMO)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0[0]), .data0(data0[0]), .ack0(ack0[0]),
    .req1(req1[0]), .data1(data1[0]), .ack1(ack1[0]),
    .tx_data(tx_data[0]), .tx_send_en(tx_send_en[0]),
    .tx_done(tx_done[0]), .busy(busy[0]), .err(err[0])
  );

  uart_frame_arbiter #(
    .HEADER(8'hA5), .GAP_CYCLES(0), .TIMEOUT(TMO)
  ) u_dut_g0 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0[1]), .data0(data0[1]), .ack0(ack0[1]),
    .req1(req1[1]), .data1(data1[1]), .ack1(ack1[1]),
    .tx_data(tx_data[1]), .tx_send_en(tx_send_en[1]),
    .tx_done(tx_done[1]), .busy(busy[1]), .err(err[1])
  );

  function automatic int gap_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic check(input bit ok, input string name,
                       input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  name, act, exp, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // transmitter model: tx_done dly cycles after send_en, or never
  initial begin
    int sends [2];
    int due [2];
    for (int i = 0; i < 2; i++) begin
      tx_done[i] = 1'b0;
      sends[i] = 0;
      due[i] = -1;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        tx_done[i] = 1'b0;
        if (!rst_n || ack0[i] || ack1[i]) sends[i] = 0;
        if (rst_n && tx_send_en[i]) begin
          sends[i]++;
          if (stall_at[i] == 0 || sends[i] < stall_at[i])
            due[i] = cyc + dly[i];
        end
        if (due[i] == cyc) begin
          tx_done[i] = 1'b1;
          due[i] = -1;
        end
      end
    end
  end

  // monitor: pops expected bytes/acks whenever the DUT presents them
  initial begin
    bit open [2];
    bit dseen [2];
    bit fall [2];
    int done_cyc [2];
    int send_cyc [2];
    logic [7:0] eb;
    logic [1:0] ea;
    for (int i = 0; i < 2; i++) begin
      open[i] = 0;
      dseen[i] = 0;
      fall[i] = 0;
      done_cyc[i] = 0;
      send_cyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          open[i] = 0;
          dseen[i] = 0;
          fall[i] = 0;
        end else begin
          if (fall[i]) begin
            check(busy[i] == 1'b0, "busy_fall", busy[i], 0);
            fall[i] = 0;
          end
          if (tx_send_en[i]) begin
            if (open[i] && dseen[i])
              check(cyc - done_cyc[i] == gap_of(i) + 1, "send_spacing",
                    cyc - done_cyc[i], gap_of(i) + 1);
            check(byte_q.size() != 0, "byte_expected", byte_q.size(), 1);
            if (byte_q.size() != 0) begin
              eb = byte_q.pop_front();
              check(tx_data[i] == eb, "tx_byte", tx_data[i], eb);
            end
            check(busy[i] == 1'b1, "busy_send", busy[i], 1);
            open[i] = 1;
            dseen[i] = 0;
            send_cyc[i] = cyc;
          end
          if (tx_done[i] && open[i]) begin
            dseen[i] = 1;
            done_cyc[i] = cyc;
          end
          if (ack0[i] || ack1[i]) begin
            check(ack_q.size() != 0, "ack_expected", ack_q.size(), 1);
            if (ack_q.size() != 0) begin
              ea = ack_q.pop_front();
              check(ack1[i] == ea[0] && ack0[i] == !ea[0], "ack_id",
                    {ack1[i], ack0[i]}, {ea[0], !ea[0]});
              check(err[i] == ea[1], "err_with_ack", err[i], ea[1]);
              if (ea[1])
                check(cyc - send_cyc[i] == TMO, "abort_latency",
                      cyc - send_cyc[i], TMO);
            end
            check(busy[i] == 1'b1, "busy_ack", busy[i], 1);
            open[i] = 0;
            fall[i] = 1;
          end
        end
      end
    end
  end

  task automatic push_frame(input logic id, input logic [31:0] d,
                            input logic [7:0] ck, input int n);
    logic [7:0] b [7];
    b[0] = 8'hA5;
    b[1] = {7'd0, id};
    b[2] = d[31:24];
    b[3] = d[23:16];
    b[4] = d[15:8];
    b[5] = d[7:0];
    b[6] = ck;
    for (int k = 0; k < n; k++) byte_q.push_back(b[k]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input int i, input string name);
    check(tx_data[i] == 8'h00, {name, "_tx_data"}, tx_data[i], 0);
    check(tx_send_en[i] == 1'b0, {name, "_send_en"}, tx_send_en[i], 0);
    check(ack0[i] == 1'b0, {name, "_ack0"}, ack0[i], 0);
    check(ack1[i] == 1'b0, {name, "_ack1"}, ack1[i], 0);
    check(busy[i] == 1'b0, {name, "_busy"}, busy[i], 0);
    check(err[i] == 1'b0, {name, "_err"}, err[i], 0);
  endtask

  task automatic wait_acks(input int i, input int n0, input int n1,
                           input int budget);
    int g0 = 0;
    int g1 = 0;
    int t = 0;
    while ((g0 < n0 || g1 < n1) && t < budget) begin
      @(negedge clk);
      t++;
      if (ack0[i]) begin
        g0++;
        req0[i] = 1'b0;
      end
      if (ack1[i]) begin
        g1++;
        req1[i] = 1'b0;
      end
    end
    check(g0 == n0 && g1 == n1, "ack_wait", {g1[3:0], g0[3:0]},
          {n1[3:0], n0[3:0]});
  endtask

  task automatic wait_sends(input int i, input int n, input int budget);
    int s = 0;
    int t = 0;
    while (s < n && t < budget) begin
      @(negedge clk);
      t++;
      if (tx_send_en[i]) s++;
    end
    check(s == n, "send_wait", s, n);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b0;
      req1[i] = 1'b0;
      data0[i] = '0;
      data1[i] = '0;
      stall_at[i] = 0;
    end
    dly[0] = 20;
    dly[1] = TMO - 1;
    rst_n = 1'b0;
    idle(2);
    check_zero(0, "rst");
    check_zero(1, "rst_g0");
    rst_n = 1'b1;
    idle(2);

    // single requester 0 frame
    data0[0] = 32'h12345678;
    push_frame(1'b0, 32'h12345678, 8'h08, 7);
    ack_q.push_back(2'b00);
    req0[0] = 1'b1;
    wait_acks(0, 1, 0, 2000);
    idle(5);

    // contention straight after reset, then again
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(2);
    data1[0] = 32'hDEADBEEF;
    for (int r = 0; r < 2; r++) begin
      push_frame(1'b0, 32'h12345678, 8'h08, 7);
      push_frame(1'b1, 32'hDEADBEEF, 8'h23, 7);
      ack_q.push_back(2'b00);
      ack_q.push_back(2'b01);
      req0[0] = 1'b1;
      req1[0] = 1'b1;
      wait_acks(0, 1, 1, 4000);
      idle(3);
    end

    // stalled transmitter after the third byte
    stall_at[0] = 3;
    push_frame(1'b0, 32'h12345678, 8'h08, 3);
    ack_q.push_back(2'b10);
    req0[0] = 1'b1;
    wait_acks(0, 1, 0, 2000);
    stall_at[0] = 0;
    idle(3);
    push_frame(1'b1, 32'hDEADBEEF, 8'h23, 7);
    ack_q.push_back(2'b01);
    req1[0] = 1'b1;
    wait_acks(0, 0, 1, 2000);
    idle(3);

    // reset in the middle of byte B3
    push_frame(1'b0, 32'h12345678, 8'h08, 7);
    ack_q.push_back(2'b00);
    req0[0] = 1'b1;
    wait_sends(0, 4, 500);
    idle(5);
    rst_n = 1'b0;
    req0[0] = 1'b0;
    byte_q.delete();
    ack_q.delete();
    idle(1);
    check_zero(0, "mid_rst");
    idle(2);
    check_zero(0, "mid_rst_hold");
    rst_n = 1'b1;
    idle(40);
    push_frame(1'b1, 32'hDEADBEEF, 8'h23, 7);
    ack_q.push_back(2'b01);
    req1[0] = 1'b1;
    wait_acks(0, 0, 1, 2000);
    idle(3);

    // req dropped and data changed mid-frame
    data0[0] = 32'h12345678;
    push_frame(1'b0, 32'h12345678, 8'h08, 7);
    ack_q.push_back(2'b00);
    req0[0] = 1'b1;
    wait_sends(0, 2, 500);
    req0[0] = 1'b0;
    data0[0] = 32'hFFFFFFFF;
    wait_acks(0, 1, 0, 2000);
    idle(60);

    // zero-gap build, tx_done on the watchdog's last cycle
    data0[1] = 32'h12345678;
    push_frame(1'b0, 32'h12345678, 8'h08, 7);
    ack_q.push_back(2'b00);
    req0[1] = 1'b1;
    wait_acks(1, 1, 0, 2000);
    idle(5);

    check(byte_q.size() == 0, "bytes_left", byte_q.size(), 0);
    check(ack_q.size() == 0, "acks_left", ack_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_arbiter.md
Name: uart_frame_arbiter

Overview:
- Sequencer and arbiter sitting in front of the single 8-bit UART byte transmitter.
- Accepts 32-bit report words from two requesters, for example the ICAPE2 readback path and a status/debug source.
- Arbitrates between them round-robin and serialises each accepted word into a fixed 7-byte frame, handing one byte at a time to the transmitter.
- Paces bytes using the transmitter's one-cycle tx_done pulse, with a watchdog so a stalled transmitter cannot hang the block.

Parameters:
- HEADER, 8'hA5, first byte of every frame.
- GAP_CYCLES, 2, idle clk cycles inserted between tx_done and the next send_en (0 allowed = back-to-back).
- TIMEOUT, 600000, max clk cycles to wait for tx_done after a send_en before aborting. Must exceed one byte time: 11 bits × 5208 clk = 57288.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  requester 0 request, level; held high until ack0
- data0  input  32  requester 0 word, stable while req0 high
- ack0  output  1  one-cycle pulse when requester 0's frame finishes or aborts
- req1  input  1  requester 1 request, level
- data1  input  32  requester 1 word
- ack1  output  1  one-cycle pulse for requester 1
- tx_data  output  8  byte to transmitter, registered
- tx_send_en  output  1  one-cycle start pulse to transmitter
- tx_done  input  1  transmitter byte-complete pulse (one cycle)
- busy  output  1  high from grant until the ack cycle inclusive
- err  output  1  one-cycle pulse, coincident with ack, when a frame aborted on timeout

Behaviour:
- Interface decisions: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: all outputs 0; state IDLE; round-robin pointer rr=0; internal counters 0.

Frame byte order:
- B0 = HEADER
- B1 = source id (8'h00 or 8'h01)
- B2..B5 = data[31:24], data[23:16], data[15:8], data[7:0]
- B6 = B1^B2^B3^B4^B5 (HEADER excluded)

State machine:
- IDLE: if any req is high, grant. If both are high, grant rr; if only one is high, grant that one. Latch the granted data word and src id into internal registers; set idx=0, busy=1; go to SEND next cycle.
- SEND: drive tx_data=B[idx] and tx_send_en=1 for exactly one cycle (registered outputs); clear the wait counter; go to WAIT.
- WAIT:
  - Wait counter increments each cycle.
  - On tx_done: if idx==6 go to DONE; else idx<=idx+1 and go to GAP (or straight to SEND when GAP_CYCLES==0).
  - If the counter reaches TIMEOUT-1 without tx_done: set the abort flag and go to DONE.
- GAP: count GAP_CYCLES cycles, then go to SEND.
- DONE:
  - Pulse ack of the granted requester for one cycle; pulse err if the abort flag is set.
  - rr <= ~granted id.
  - Clear busy on the following cycle; return to IDLE.

Rules:
- Minimum spacing from tx_done to the next tx_send_en is GAP_CYCLES+1 cycles.
- A tx_done arriving outside WAIT is ignored.
- tx_done and timeout in the same cycle: tx_done wins, so no err.
- A requester dropping req mid-frame has no effect: the frame completes and is still acked.
- Data changes after the grant are ignored because the word is latched.
- The requester must deassert req in the cycle after ack. If req is still high in IDLE, it is treated as a new request.
- Fairness: after serving id N, the other id wins the next contention. A lone requester may be served repeatedly.
- Checksum: 8-bit XOR, no carry.
- Reset asserted mid-frame: immediate return to reset values; no ack, no err, no partial frame resumed. The transmitter may finish its current byte independently, and the resulting tx_done is ignored in IDLE.

Test Plan:
- req0 with data0=32'h12345678; transmitter model returns tx_done 20 cycles after each send_en. Required: bytes A5 00 12 34 56 78 08 in order, each send_en exactly GAP_CYCLES+1 cycles after the prior tx_done, then one ack0 pulse, err=0.
- req0 and req1 asserted together after reset, data1=32'hDEADBEEF. Required: requester 0 frame first, then requester 1 frame A5 01 DE AD BE EF 23, and ack1 only after ack0. A repeated simultaneous request then serves requester 0 first again, since rr=0 after requester 1.
- Transmitter model never returns tx_done after the third send_en (byte 8'h12), with TIMEOUT=100 for the test. Required: tx_send_en pulsed exactly 3 times; err and ack0 pulse together 100 cycles after the third send_en; busy falls; block accepts the next request normally.
- GAP_CYCLES=0 build with tx_done simultaneous with the timeout cycle. Required: back-to-back send_en on the cycle after tx_done; no err.
- Reset asserted during byte B3 of a frame, then req1 raised. Required: all outputs 0 during reset, no ack0, and a fresh, complete requester-1 frame starting with A5.
- req0 dropped and data0 changed mid-frame. Required: original latched bytes still sent intact and ack0 pulses once.
